// File: rtl/checkpoint_monitor_if.sv
// Run-control and status bundle for checkpoint_monitor.
// The slave side is the monitor, the master side drives it.
interface checkpoint_monitor_if #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
);
  logic                    start;
  logic                    clear;
  logic [WIDTH-1:0]        checkbits;
  logic [STAGES*WIDTH-1:0] expected;
  logic [4:0]              num_stages;
  logic [31:0]             timeout_cycles;
  logic                    fail_en;
  logic [WIDTH-1:0]        fail_value;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic                    fail;
  logic [1:0]              fail_reason;
  logic [4:0]              stage_idx;
  logic                    stage_hit;
  logic [31:0]             elapsed;

  modport master (
    output start, clear, checkbits, expected,
    output num_stages, timeout_cycles,
    output fail_en, fail_value,
    input  busy, done, pass, fail,
    input  fail_reason, stage_idx,
    input  stage_hit, elapsed
  );

  modport slave (
    input  start, clear, checkbits, expected,
    input  num_stages, timeout_cycles,
    input  fail_en, fail_value,
    output busy, done, pass, fail,
    output fail_reason, stage_idx,
    output stage_hit, elapsed
  );
endinterface

// File: rtl/checkpoint_monitor.sv
// Watches a status bus for an ordered list of checkpoint codes,
// with stability filtering, abort-code detection and a run timeout.
module checkpoint_monitor #(
  parameter int WIDTH        = 16,
  parameter int STAGES       = 4,
  parameter int STABLE       = 1,
  parameter int PER_STAGE_TO = 0
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  checkpoint_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam logic [4:0] STG_MAX = 5'(STAGES);
  localparam logic [8:0] STB     = 9'(STABLE);
  localparam bit         PER_TO  = (PER_STAGE_TO != 0);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sample_q;
  logic [4:0]       stage_q;
  logic [4:0]       stage_d;
  logic [4:0]       nstg_q;
  logic [4:0]       nstg_d;
  logic [31:0]      to_q;
  logic [31:0]      to_d;
  logic [31:0]      timer_q;
  logic [31:0]      timer_d;
  logic [31:0]      elapsed_q;
  logic [31:0]      elapsed_d;
  logic [7:0]       stab_q;
  logic [7:0]       stab_d;
  logic [1:0]       reason_q;
  logic [1:0]       reason_d;
  logic             hit_q;
  logic             hit_d;

  logic [WIDTH-1:0] exp_cur;
  logic [4:0]       nstg_clamp;
  logic [8:0]       stab_inc;
  logic             in_wait;
  logic             match;
  logic             hit;
  logic             abort;
  logic             tmo;
  logic             do_clr;
  logic             do_go;
  logic             do_run;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sample_q <= '0;
    end else begin
      sample_q <= bus.checkbits;
    end
  end

  always_comb begin
    exp_cur = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (stage_q == 5'(i)) begin
        exp_cur = bus.expected[i*WIDTH +: WIDTH];
      end
    end
  end

  assign nstg_clamp = (bus.num_stages > STG_MAX) ?
                      STG_MAX : bus.num_stages;

  assign in_wait  = (state_q == ST_WAIT);
  assign match    = (sample_q == exp_cur);
  assign stab_inc = {1'b0, stab_q} + 9'd1;

  // Hit beats abort beats timeout on the same edge.
  assign hit   = in_wait && match && (stab_inc == STB);
  assign abort = in_wait && !hit && bus.fail_en &&
                 (sample_q == bus.fail_value);
  assign tmo   = in_wait && !hit && (to_q != 32'd0) &&
                 (timer_q + 32'd1 == to_q);

  assign do_clr = bus.clear;
  assign do_go  = !bus.clear && bus.start && !in_wait;
  assign do_run = !bus.clear && in_wait;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    nstg_d    = nstg_q;
    to_d      = to_q;
    timer_d   = timer_q;
    elapsed_d = elapsed_q;
    stab_d    = stab_q;
    reason_d  = reason_q;
    hit_d     = 1'b0;
    unique case (1'b1)
      do_clr: begin
        state_d   = ST_IDLE;
        stage_d   = '0;
        nstg_d    = '0;
        to_d      = '0;
        timer_d   = '0;
        elapsed_d = '0;
        stab_d    = '0;
        reason_d  = 2'b00;
      end
      do_go: begin
        state_d   = (nstg_clamp == 5'd0) ? ST_PASS : ST_WAIT;
        stage_d   = '0;
        nstg_d    = nstg_clamp;
        to_d      = bus.timeout_cycles;
        timer_d   = '0;
        elapsed_d = '0;
        stab_d    = '0;
        reason_d  = 2'b00;
      end
      do_run: begin
        elapsed_d = (&elapsed_q) ? elapsed_q : elapsed_q + 32'd1;
        timer_d   = timer_q + 32'd1;
        stab_d    = match ? stab_inc[7:0] : 8'd0;
        if (hit) begin
          hit_d   = 1'b1;
          stab_d  = '0;
          stage_d = stage_q + 5'd1;
          if (PER_TO) begin
            timer_d = '0;
          end
          if (stage_q + 5'd1 == nstg_q) begin
            state_d = ST_PASS;
          end
        end else if (abort) begin
          state_d  = ST_FAIL;
          reason_d = 2'b10;
        end else if (tmo) begin
          state_d  = ST_FAIL;
          reason_d = 2'b01;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      nstg_q    <= '0;
      to_q      <= '0;
      timer_q   <= '0;
      elapsed_q <= '0;
      stab_q    <= '0;
      reason_q  <= 2'b00;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      nstg_q    <= nstg_d;
      to_q      <= to_d;
      timer_q   <= timer_d;
      elapsed_q <= elapsed_d;
      stab_q    <= stab_d;
      reason_q  <= reason_d;
      hit_q     <= hit_d;
    end
  end

  assign bus.busy        = (state_q == ST_WAIT);
  assign bus.done        = (state_q == ST_PASS) ||
                           (state_q == ST_FAIL);
  assign bus.pass        = (state_q == ST_PASS);
  assign bus.fail        = (state_q == ST_FAIL);
  assign bus.fail_reason = reason_q;
  assign bus.stage_idx   = stage_q;
  assign bus.stage_hit   = hit_q;
  assign bus.elapsed     = elapsed_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Directed bench for checkpoint_monitor: a run-level reference model
// checked every cycle on one instance, plus literal checks on both.
module tb_checkpoint_monitor;

  localparam int W = 16;
  localparam int S = 4;
  localparam int MS = 1;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_PASS = 2;
  localparam int P_FAIL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;
  int hits_a = 0;
  int hits_b = 0;
  int base;

  always #5 clk = ~clk;

  checkpoint_monitor_if #(.WIDTH(W), .STAGES(S)) a ();
  checkpoint_monitor_if #(.WIDTH(W), .STAGES(S)) b ();

  checkpoint_monitor #(
    .WIDTH(W), .STAGES(S), .STABLE(1), .PER_STAGE_TO(0)
  ) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(a)
  );

  checkpoint_monitor #(
    .WIDTH(W), .STAGES(S), .STABLE(3), .PER_STAGE_TO(1)
  ) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(b)
  );

  // reference model for dut_a
  int          m_phase = P_IDLE;
  int          m_idx = 0;
  int          m_n = 0;
  int          m_streak = 0;
  logic [1:0]  m_reason = 2'b00;
  logic        m_pulse = 1'b0;
  logic [15:0] m_samp = '0;
  logic [15:0] m_prev = '0;
  logic [31:0] m_to = '0;
  logic [31:0] m_t = '0;
  logic [31:0] m_el = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = P_IDLE; m_idx = 0; m_n = 0; m_streak = 0;
        m_reason = 2'b00; m_pulse = 1'b0; m_samp = '0;
        m_to = '0; m_t = '0; m_el = '0;
      end else begin
        m_prev  = m_samp;
        m_samp  = a.checkbits;
        m_pulse = 1'b0;
        if (a.clear) begin
          m_phase = P_IDLE; m_idx = 0; m_el = '0; m_reason = 2'b00;
        end else if (a.start && m_phase != P_RUN) begin
          m_n = (int'(a.num_stages) > S) ? S : int'(a.num_stages);
          m_to = a.timeout_cycles;
          m_idx = 0; m_el = '0; m_t = '0; m_streak = 0;
          m_reason = 2'b00;
          m_phase = (m_n == 0) ? P_PASS : P_RUN;
        end else if (m_phase == P_RUN) begin
          if (m_el != 32'hFFFF_FFFF) m_el = m_el + 1;
          m_t = m_t + 1;
          if (m_prev == a.expected[m_idx*W +: W]) m_streak++;
          else m_streak = 0;
          if (m_streak == MS) begin
            m_pulse = 1'b1;
            m_idx++;
            m_streak = 0;
            if (m_idx == m_n) m_phase = P_PASS;
          end else if (a.fail_en && m_prev == a.fail_value) begin
            m_phase = P_FAIL; m_reason = 2'b10;
          end else if (m_to != 0 && m_t == m_to) begin
            m_phase = P_FAIL; m_reason = 2'b01;
          end
        end
      end
    end
  end

  initial begin
    logic [44:0] act;
    logic [44:0] exp;
    forever begin
      @(negedge clk);
      act = {a.busy, a.done, a.pass, a.fail, a.fail_reason,
             a.stage_idx, a.stage_hit, a.elapsed};
      exp = {m_phase == P_RUN,
             m_phase == P_PASS || m_phase == P_FAIL,
             m_phase == P_PASS, m_phase == P_FAIL, m_reason,
             5'(m_idx), m_pulse, m_el};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL cycle@%0t: got %h expected %h", $time, act, exp);
      end
      if (a.stage_hit) hits_a++;
      if (b.stage_hit) hits_b++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drv_a(logic [15:0] v, int n);
    a.checkbits = v;
    tick(n);
  endtask

  task automatic drv_b(logic [15:0] v, int n);
    b.checkbits = v;
    tick(n);
  endtask

  task automatic start_a();
    a.start = 1'b1;
    tick(1);
    a.start = 1'b0;
  endtask

  task automatic start_b();
    b.start = 1'b1;
    tick(1);
    b.start = 1'b0;
  endtask

  task automatic seq_basic();
    start_a();
    drv_a(16'hAB60, 1);
    drv_a(16'hAB61, 1);
    drv_a(16'h0000, 3);
  endtask

  initial begin
    a.start = 0; a.clear = 0; a.checkbits = '0;
    a.expected = {16'h0, 16'h0, 16'hAB61, 16'hAB60};
    a.num_stages = 5'd2; a.timeout_cycles = 32'd1000;
    a.fail_en = 0; a.fail_value = 16'hDEAD;
    b.start = 0; b.clear = 0; b.checkbits = '0;
    b.expected = {16'h0, 16'h0, 16'hAB61, 16'hAB60};
    b.num_stages = 5'd2; b.timeout_cycles = 32'd0;
    b.fail_en = 0; b.fail_value = 16'hDEAD;

    tick(3);
    chk("reset_busy", {31'd0, a.busy}, 32'd0);
    chk("reset_done", {31'd0, a.done}, 32'd0);
    rst = 1'b0;
    tick(2);

    base = hits_a;
    seq_basic();
    chk("basic_pass", {31'd0, a.pass}, 32'd1);
    chk("basic_stage", {27'd0, a.stage_idx}, 32'd2);
    chk("basic_reason", {30'd0, a.fail_reason}, 32'd0);
    chk("basic_hits", 32'(hits_a - base), 32'd2);
    chk("basic_elapsed", a.elapsed, 32'd3);

    base = hits_a;
    start_a();
    drv_a(16'hAB61, 1);
    drv_a(16'hAB60, 1);
    drv_a(16'hAB61, 1);
    drv_a(16'h0000, 3);
    chk("order_pass", {31'd0, a.pass}, 32'd1);
    chk("order_hits", 32'(hits_a - base), 32'd2);

    a.timeout_cycles = 32'd50;
    start_a();
    drv_a(16'h0000, 60);
    chk("tmo_fail", {31'd0, a.fail}, 32'd1);
    chk("tmo_reason", {30'd0, a.fail_reason}, 32'd1);
    chk("tmo_elapsed", a.elapsed, 32'd50);
    chk("tmo_stage", {27'd0, a.stage_idx}, 32'd0);

    a.timeout_cycles = 32'd1000;
    a.fail_en = 1'b1;
    start_a();
    drv_a(16'hAB60, 1);
    drv_a(16'hDEAD, 1);
    drv_a(16'h0000, 2);
    chk("abort_reason", {30'd0, a.fail_reason}, 32'd2);
    chk("abort_stage", {27'd0, a.stage_idx}, 32'd1);
    chk("abort_elapsed", a.elapsed, 32'd3);

    a.expected = {16'h0, 16'h0, 16'hAB61, 16'hDEAD};
    start_a();
    drv_a(16'hDEAD, 1);
    drv_a(16'hAB61, 1);
    drv_a(16'h0000, 2);
    chk("hit_over_abort", {31'd0, a.pass}, 32'd1);
    chk("hit_over_abort_stage", {27'd0, a.stage_idx}, 32'd2);
    a.fail_en = 1'b0;

    a.expected = {16'h0, 16'h0, 16'hAB61, 16'hAB60};
    start_a();
    drv_a(16'hAB60, 1);
    a.start = 1'b1;
    drv_a(16'h0000, 1);
    a.start = 1'b0;
    drv_a(16'h0000, 2);
    chk("start_in_wait_busy", {31'd0, a.busy}, 32'd1);
    chk("start_in_wait_stage", {27'd0, a.stage_idx}, 32'd1);
    a.clear = 1'b1;
    tick(1);
    a.clear = 1'b0;
    chk("clear_busy", {31'd0, a.busy}, 32'd0);
    chk("clear_stage", {27'd0, a.stage_idx}, 32'd0);
    a.clear = 1'b1; a.start = 1'b1;
    tick(1);
    a.clear = 1'b0; a.start = 1'b0;
    chk("clear_over_start", {31'd0, a.busy}, 32'd0);

    a.num_stages = 5'd0;
    start_a();
    chk("zero_stages_pass", {31'd0, a.pass}, 32'd1);
    chk("zero_stages_idx", {27'd0, a.stage_idx}, 32'd0);

    a.num_stages = 5'd9;
    a.expected = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    start_a();
    drv_a(16'h1111, 1);
    drv_a(16'h2222, 1);
    drv_a(16'h3333, 1);
    drv_a(16'h4444, 1);
    drv_a(16'h0000, 3);
    chk("clamp_pass", {31'd0, a.pass}, 32'd1);
    chk("clamp_stage", {27'd0, a.stage_idx}, 32'd4);

    a.num_stages = 5'd2;
    a.expected = {16'h0, 16'h0, 16'hAB61, 16'hAB60};
    start_a();
    drv_a(16'hAB60, 1);
    drv_a(16'h0000, 2);
    chk("pre_rst_stage", {27'd0, a.stage_idx}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, a.busy}, 32'd0);
    chk("rst_stage", {27'd0, a.stage_idx}, 32'd0);
    chk("rst_elapsed", a.elapsed, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    seq_basic();
    chk("post_rst_pass", {31'd0, a.pass}, 32'd1);
    chk("post_rst_stage", {27'd0, a.stage_idx}, 32'd2);

    base = hits_b;
    start_b();
    drv_b(16'hAB60, 2);
    drv_b(16'h0000, 2);
    chk("stable_short_hits", 32'(hits_b - base), 32'd0);
    drv_b(16'hAB60, 3);
    drv_b(16'h0000, 3);
    chk("stable_hits", 32'(hits_b - base), 32'd1);
    chk("stable_stage", {27'd0, b.stage_idx}, 32'd1);

    b.clear = 1'b1;
    tick(1);
    b.clear = 1'b0;
    b.timeout_cycles = 32'd10;
    start_b();
    drv_b(16'hAB60, 3);
    drv_b(16'h0000, 7);
    chk("per_stage_busy", {31'd0, b.busy}, 32'd1);
    drv_b(16'h0000, 8);
    chk("per_stage_reason", {30'd0, b.fail_reason}, 32'd1);
    chk("per_stage_elapsed", b.elapsed, 32'd14);
    chk("per_stage_idx", {27'd0, b.stage_idx}, 32'd1);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/checkpoint_monitor.md
CHECKPOINT_MONITOR -- requirements
Module: checkpoint_monitor

Interface
REQ-001 Parameter WIDTH, 16, checkbits/code width in bits (1..32).
REQ-002 Parameter STAGES, 4, maximum number of ordered checkpoint codes (1..16).
REQ-003 Parameter STABLE, 1, consecutive sampled cycles a code must hold to count as a hit (1..255).
REQ-004 Parameter PER_STAGE_TO, 0, timeout mode: 0 = global from start, 1 = timer restarts on every hit.
REQ-005 Reset is asynchronous and active-high; the block has one clock. Ports: wb_clk_i and wb_rst_i.
REQ-006 wb_clk_i  in  1  clock.
REQ-007 wb_rst_i  in  1  asynchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse that launches a run.
REQ-009 clear  in  1  one-cycle pulse that returns the block to IDLE.
REQ-010 checkbits  in  WIDTH  observed status bus (asynchronous to the run, single-sampled).
REQ-011 expected  in  STAGES*WIDTH  code list; stage i occupies bits [i*WIDTH +: WIDTH]; held stable while busy.
REQ-012 num_stages  in  5  number of stages used; latched at start.
REQ-013 timeout_cycles  in  32  timeout limit; 0 disables the timeout; latched at start.
REQ-014 fail_en, fail_value  in  1, WIDTH  abort-code enable and abort code.
REQ-015 busy, done, pass, fail  out  1 each  run status.
REQ-016 fail_reason  out  2  00 none, 01 timeout, 10 abort.
REQ-017 stage_idx  out  5  number of stages hit so far.
REQ-018 stage_hit  out  1  one-cycle pulse per accepted stage.
REQ-019 elapsed  out  32  cycles since start, saturating at 0xFFFFFFFF, frozen in PASS/FAIL.

Function
REQ-020 States are IDLE, WAIT, PASS and FAIL; busy=1 only in WAIT; done=1 in PASS or FAIL; pass=1 only in PASS; fail=1 only in FAIL.
REQ-021 checkbits is registered once into sample_q every cycle, regardless of state.
REQ-022 Transitions: IDLE+start goes to WAIT with stage_idx=0, elapsed=0, timer=0 and the stability counter cleared; a start in PASS or FAIL restarts the run identically; a start in WAIT is ignored.
REQ-023 num_stages is clamped to STAGES at latch time; if the latched value is 0, start goes to PASS on the next edge with no stage_hit.
REQ-024 Stability counter: in WAIT it increments while sample_q equals expected[stage_idx] and clears to 0 on any mismatch; a hit occurs on the edge at which the count reaches STABLE.
REQ-025 Latency with STABLE=1: checkbits valid before edge k makes stage_hit high for the single cycle following edge k+1.
REQ-026 On a hit: stage_idx increments, the stability counter clears, and the timer clears if PER_STAGE_TO=1; the hit that makes stage_idx equal num_stages moves the block to PASS.
REQ-027 Codes that do not match the current stage, including codes for later stages, are ignored; there is no ordering error.
REQ-028 Abort: in WAIT, if fail_en=1 and sample_q == fail_value with no hit on that edge, the block goes to FAIL with fail_reason=10.
REQ-029 Timeout: the timer counts every WAIT cycle; when timer+1 == timeout_cycles (nonzero) with no hit on that edge, the block goes to FAIL with fail_reason=01.
REQ-030 Priority on the same edge: hit > abort > timeout; clear overrides start; start overrides everything else.
REQ-031 clear from any state goes to IDLE and zeroes every output except that sample_q keeps sampling.
REQ-032 stage_idx, elapsed and fail_reason hold their values in PASS and FAIL until the next start or clear.

Reset
REQ-033 Asserting wb_rst_i at any time, including mid-WAIT, forces IDLE immediately and sets every output, sample_q, the timer and the stability counter to 0.
REQ-034 After wb_rst_i is released, the first start behaves per REQ-022.

Verification
REQ-035 WIDTH=16, expected={AB61,AB60}, num_stages=2, timeout 1000; drive AB60 then AB61 -> two stage_hit pulses, pass=1, stage_idx=2, fail_reason=00.
REQ-036 Same setup, drive AB61, then AB60, then AB61 -> the first AB61 is ignored, pass=1 after the final AB61.
REQ-037 Global mode, timeout 50, bus stays 0000 -> fail=1, fail_reason=01, elapsed=50, stage_idx=0.
REQ-038 fail_en=1, fail_value=DEAD; after an AB60 hit, drive DEAD -> fail_reason=10, stage_idx=1; a driven value equal to both the expected code and fail_value gives a hit, not an abort.
REQ-039 STABLE=3: AB60 held 2 cycles then 0000 gives no hit; AB60 held 3 cycles gives exactly one hit.
REQ-040 Assert wb_rst_i mid-WAIT after one hit -> all outputs 0 in IDLE; a following start and the sequence of REQ-035 pass.
